// File: rtl/mips_pkg.sv
// mips_pkg: opcode constants, MEM/WB bundle layout and the write-capable opcode decode.
package mips_pkg;
  localparam int MW_W     = 44;
  localparam int OP_W     = 6;
  localparam int DATA_W   = 32;
  localparam int REG_W    = 5;
  localparam int OP_LSB   = 38;
  localparam int DATA_LSB = 6;
  localparam int DEST_LSB = 1;
  localparam int LOAD_BIT = 0;
  localparam logic [OP_W-1:0] OP_RTYPE = 6'd0;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'd8;
  localparam logic [OP_W-1:0] OP_ADDIU = 6'd9;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'd10;
  localparam logic [OP_W-1:0] OP_SLTIU = 6'd11;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'd12;
  localparam logic [OP_W-1:0] OP_ORI   = 6'd13;
  localparam logic [OP_W-1:0] OP_XORI  = 6'd14;
  localparam logic [OP_W-1:0] OP_LUI   = 6'd15;
  localparam logic [OP_W-1:0] OP_LW    = 6'd35;
  localparam logic [OP_W-1:0] OP_SW    = 6'd43;
  function automatic logic op_writes(input logic [OP_W-1:0] op);
    return op == OP_RTYPE || (op >= OP_ADDI && op <= OP_LUI) || op == OP_LW;
  endfunction
endpackage

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: 32x32 register file, two combinational read ports with write bypass, one sync write port.
module regfile_2r1w
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [REG_W-1:0]  i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [REG_W-1:0]  i_ra_addr,
  input  logic [REG_W-1:0]  i_rb_addr,
  output logic [DATA_W-1:0] o_ra_data,
  output logic [DATA_W-1:0] o_rb_data
);
  logic [DATA_W-1:0] r_regs [32];
  logic              w_wr;
  assign w_wr = i_we && i_waddr != '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (w_wr) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end
  // r0 and reset force zero ahead of the bypass so neither can leak a value
  assign o_ra_data = (!rst_n || i_ra_addr == '0) ? '0 :
                     (w_wr && i_waddr == i_ra_addr) ? i_wdata : r_regs[i_ra_addr];
  assign o_rb_data = (!rst_n || i_rb_addr == '0) ? '0 :
                     (w_wr && i_waddr == i_rb_addr) ? i_wdata : r_regs[i_rb_addr];
endmodule

// File: rtl/write_back_stage.sv
// write_back_stage: MEM/WB decode, register write/forward and perf counters (counters built only with WB_PERF_CNT_EN).
module write_back_stage
  import mips_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [MW_W-1:0]   mem_wb,
  input  logic [REG_W-1:0]  rs_addr,
  input  logic [REG_W-1:0]  rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              wb_fwd_en,
  output logic [REG_W-1:0]  wb_fwd_reg,
  output logic [DATA_W-1:0] wb_fwd_data,
  output logic [CNT_W-1:0]  retire_cnt,
  output logic [CNT_W-1:0]  load_cnt
);
  logic [OP_W-1:0]   w_op;
  logic [DATA_W-1:0] w_data;
  logic [REG_W-1:0]  w_dest;
  logic              w_we;
  logic              w_unused_is_load;
  assign w_op             = mem_wb[OP_LSB +: OP_W];
  assign w_data           = mem_wb[DATA_LSB +: DATA_W];
  assign w_dest           = mem_wb[DEST_LSB +: REG_W];
  assign w_unused_is_load = mem_wb[LOAD_BIT];
  assign w_we             = op_writes(w_op) && w_dest != '0;
  assign wb_fwd_en        = w_we;
  assign wb_fwd_reg       = w_dest;
  assign wb_fwd_data      = w_data;
  regfile_2r1w u_rf (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_we      (w_we),
    .i_waddr   (w_dest),
    .i_wdata   (w_data),
    .i_ra_addr (rs_addr),
    .i_rb_addr (rt_addr),
    .o_ra_data (rs_data),
    .o_rb_data (rt_data)
  );
`ifdef WB_PERF_CNT_EN
  logic [CNT_W-1:0] r_retire;
  logic [CNT_W-1:0] r_load;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retire <= '0;
      r_load   <= '0;
    end else begin
      if (mem_wb != '0 && r_retire != '1) r_retire <= r_retire + CNT_W'(1);
      if (w_op == OP_LW && r_load != '1) r_load <= r_load + CNT_W'(1);
    end
  end
  assign retire_cnt = r_retire;
  assign load_cnt   = r_load;
`else
  assign retire_cnt = '0;
  assign load_cnt   = '0;
`endif
endmodule

// File: tb/tb_write_back_stage.sv
// tb_write_back_stage: directed vectors checked every cycle against a behavioural register-file model.
module tb_write_back_stage;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;
  logic          clk = 0;
  logic          rst_n;
  logic [43:0]   mem_wb;
  logic [4:0]    rs_addr, rt_addr;
  logic [31:0]   rs_data, rt_data, wb_fwd_data;
  logic          wb_fwd_en;
  logic [4:0]    wb_fwd_reg;
  logic [CW-1:0] retire_cnt, load_cnt;
  int tests = 0, fails = 0;
  logic [31:0] m_regs [32];
  int m_ret, m_ld;
`ifdef WB_PERF_CNT_EN
  localparam bit PERF = 1;
`else
  localparam bit PERF = 0;
`endif

  write_back_stage #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .mem_wb(mem_wb), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data), .rt_data(rt_data), .wb_fwd_en(wb_fwd_en), .wb_fwd_reg(wb_fwd_reg),
    .wb_fwd_data(wb_fwd_data), .retire_cnt(retire_cnt), .load_cnt(load_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [43:0] mw(input int op, input logic [31:0] d, input int rd, input bit ld);
    return {6'(op), d, 5'(rd), ld};
  endfunction

  function automatic bit m_we();
    int op = int'(mem_wb[43:38]);
    return (op == 0 || (op >= 8 && op <= 15) || op == 35) && mem_wb[5:1] != 0;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (!rst_n || a == 0) return 0;
    if (m_we() && a == mem_wb[5:1]) return mem_wb[37:6];
    return m_regs[a];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 0;
      m_ret = 0;
      m_ld  = 0;
    end else begin
      if (m_we()) m_regs[mem_wb[5:1]] = mem_wb[37:6];
      if (PERF && mem_wb != 0 && m_ret < CMAX) m_ret++;
      if (PERF && mem_wb[43:38] == 6'd35 && m_ld < CMAX) m_ld++;
    end
  end

  always @(negedge clk) begin
    chk("rs_data", rs_data, m_read(rs_addr));
    chk("rt_data", rt_data, m_read(rt_addr));
    chk("fwd_en", wb_fwd_en, m_we());
    chk("fwd_reg", wb_fwd_reg, mem_wb[5:1]);
    chk("fwd_data", wb_fwd_data, mem_wb[37:6]);
    chk("retire_cnt", retire_cnt, m_ret);
    chk("load_cnt", load_cnt, m_ld);
  end

  task automatic step(input logic [43:0] m, input logic [4:0] a, input logic [4:0] b);
    @(posedge clk);
    #1;
    mem_wb  = m;
    rs_addr = a;
    rt_addr = b;
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst_n = 0; mem_wb = 0; rs_addr = 5; rt_addr = 31;
    #23;
    chk("rst_rs", rs_data, 0);
    chk("rst_rt", rt_data, 0);
    chk("rst_ret", retire_cnt, 0);
    chk("rst_ld", load_cnt, 0);
    @(negedge clk); rst_n = 1;
    step(mw(35, 32'hDEADBEEF, 7, 1), 7, 0);
    chk("lw_bypass", rs_data, 32'hDEADBEEF);
    chk("lw_fwd_en", wb_fwd_en, 1);
    step(0, 7, 7);
    chk("lw_stored_rs", rs_data, 32'hDEADBEEF);
    chk("lw_stored_rt", rt_data, 32'hDEADBEEF);
    chk("lw_load_cnt", load_cnt, PERF ? 1 : 0);
    step(mw(0, 32'h12345678, 0, 0), 0, 0);
    chk("r0_fwd_en", wb_fwd_en, 0);
    chk("r0_read", rs_data, 0);
    step(mw(13, 32'h0000F0F0, 9, 0), 9, 0);
    chk("rtype_retire", retire_cnt, PERF ? 2 : 0);
    chk("ori_bypass", rs_data, 32'h0000F0F0);
    step(mw(43, 32'hAAAA5555, 9, 0), 9, 9);
    chk("sw_fwd_en", wb_fwd_en, 0);
    chk("sw_no_bypass", rt_data, 32'h0000F0F0);
    step(0, 9, 0);
    chk("sw_no_write", rs_data, 32'h0000F0F0);
    step(mw(8, 32'h00000011, 10, 1), 10, 10);
    step(mw(4, 32'h44444444, 11, 0), 11, 10);
    chk("isload_addi", rt_data, 32'h00000011);
    step(mw(2, 32'h22222222, 11, 0), 11, 0);
    chk("j_no_write", rs_data, 0);
    step(mw(0, 32'hCAFEF00D, 31, 0), 31, 31);
    chk("rtype_bypass_rt", rt_data, 32'hCAFEF00D);
    for (int i = 0; i < 20; i++) step(mw(35, 32'h1000 + i, (i % 30) + 1, 1), 5'((i % 30) + 1), 31);
    step(0, 20, 31);
    chk("sat_ret", retire_cnt, PERF ? CMAX : 0);
    chk("sat_ld", load_cnt, PERF ? CMAX : 0);
    chk("last_lw", rs_data, 32'h1013);
    step(mw(8, 32'h1, 3, 0), 3, 3);
    step(0, 3, 3);
    chk("r3_set", rs_data, 32'h1);
    #2 rst_n = 0;
    #1;
    chk("async_r3", rs_data, 0);
    chk("async_ret", retire_cnt, 0);
    chk("async_ld", load_cnt, 0);
    @(posedge clk); #1;
    mem_wb = mw(8, 32'h77, 3, 0);
    @(negedge clk); rst_n = 1; #1;
    chk("coincident_bypass", rs_data, 32'h77);
    step(0, 3, 7);
    chk("post_reset_r3", rs_data, 32'h77);
    chk("post_reset_r7", rt_data, 0);
    step(0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    fails++;
    $display("FAIL timeout: run exceeded time budget");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end
endmodule
